gray_codec_pipe: RTL and testbench

- Pipelined, bidirectional Gray/binary converter with valid/ready flow control, for multi-bit pointers and counters crossing between clock domains.
- Each input beat has its own mode bit:
  - decode: Gray to binary;
  - encode: binary to Gray.
- Results travel through a parametrised register pipeline with full throughput and backpressure.
- It replaces the earlier purely combinational converter in pointer-sync paths.

---
 rtl/gray_codec_pipe.sv | 142 ++++++++++++++
 tb/tb_gray_codec_pipe.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gray_codec_pipe.sv
// Pipelined bidirectional Gray/binary converter with valid/ready flow control.
// Optional Gray step checker enabled by defining GRAY_CODEC_STEP_CHK_EN.
module gray_codec_pipe #(
    parameter int DATA_WIDTH = 16,
    parameter int STAGES     = 2
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_mode,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_mode,
    output logic [DATA_WIDTH-1:0] out_data
`ifdef GRAY_CODEC_STEP_CHK_EN
    ,
    output logic                  step_err
`endif
);

    logic [STAGES-1:0]     valid_q;
    logic [STAGES-1:0]     valid_d;
    logic                  mode_q [STAGES];
    logic                  mode_d [STAGES];
    logic [DATA_WIDTH-1:0] data_q [STAGES];
    logic [DATA_WIDTH-1:0] data_d [STAGES];
    logic [STAGES-1:0]     free_c;
    logic                  free_chain;
    logic                  alive_q;
    logic                  accept;
    logic [DATA_WIDTH-1:0] conv_c;
    logic                  dec_acc;

    // A stage may load when empty or when everything downstream lets it move on.
    always_comb begin
        free_c     = '0;
        free_chain = !valid_q[STAGES-1] || out_ready;
        free_c[STAGES-1] = free_chain;
        for (int k = STAGES - 2; k >= 0; k--) begin
            free_chain = !valid_q[k] || free_chain;
            free_c[k]  = free_chain;
        end
    end

    assign in_ready = alive_q && free_c[0];
    assign accept   = in_valid && in_ready;

    always_comb begin
        dec_acc = 1'b0;
        conv_c  = in_data ^ (in_data >> 1);
        if (!in_mode) begin
            for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
                dec_acc   = dec_acc ^ in_data[i];
                conv_c[i] = dec_acc;
            end
        end
    end

`ifdef GRAY_CODEC_STEP_CHK_EN
    localparam logic [DATA_WIDTH-1:0] ONE = DATA_WIDTH'(1);
    logic                  err_q [STAGES];
    logic                  err_d [STAGES];
    logic [DATA_WIDTH-1:0] prev_q;
    logic                  have_prev_q;
    logic [DATA_WIDTH-1:0] diff_c;
    logic                  step_err_c;

    // Exactly one bit changed means diff is a nonzero power of two.
    always_comb begin
        diff_c     = in_data ^ prev_q;
        step_err_c = 1'b0;
        if (!in_mode && have_prev_q)
            step_err_c = !((diff_c != '0) && ((diff_c & (diff_c - ONE)) == '0));
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            prev_q      <= '0;
            have_prev_q <= 1'b0;
        end else if (accept && !in_mode) begin
            prev_q      <= in_data;
            have_prev_q <= 1'b1;
        end
    end

    assign step_err = err_q[STAGES-1];
`endif

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            if (gi == 0) begin : g_head
                assign valid_d[gi] = accept;
                assign mode_d[gi]  = in_mode;
                assign data_d[gi]  = conv_c;
`ifdef GRAY_CODEC_STEP_CHK_EN
                assign err_d[gi]   = step_err_c;
`endif
            end else begin : g_body
                assign valid_d[gi] = valid_q[gi-1];
                assign mode_d[gi]  = mode_q[gi-1];
                assign data_d[gi]  = data_q[gi-1];
`ifdef GRAY_CODEC_STEP_CHK_EN
                assign err_d[gi]   = err_q[gi-1];
`endif
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            alive_q <= 1'b0;
            valid_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                mode_q[k] <= 1'b0;
                data_q[k] <= '0;
`ifdef GRAY_CODEC_STEP_CHK_EN
                err_q[k]  <= 1'b0;
`endif
            end
        end else begin
            alive_q <= 1'b1;
            for (int k = 0; k < STAGES; k++) begin
                if (free_c[k]) begin
                    valid_q[k] <= valid_d[k];
                    mode_q[k]  <= mode_d[k];
                    data_q[k]  <= data_d[k];
`ifdef GRAY_CODEC_STEP_CHK_EN
                    err_q[k]   <= err_d[k];
`endif
                end
            end
        end
    end

    assign out_valid = valid_q[STAGES-1];
    assign out_mode  = mode_q[STAGES-1];
    assign out_data  = data_q[STAGES-1];

endmodule

// File: tb/tb_gray_codec_pipe.sv
// Self-checking bench for gray_codec_pipe: directed vector table, flow-control
// corner sequences and randomized traffic against a queue-based reference model.
module tb_gray_codec_pipe;
    localparam int W = 16;
    localparam int S = 2;

    logic         clk = 1'b0;
    logic         resetn = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic         in_mode = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic         out_mode;
    logic [W-1:0] out_data;
`ifdef GRAY_CODEC_STEP_CHK_EN
    logic         step_err;
`endif

    gray_codec_pipe #(.DATA_WIDTH(W), .STAGES(S)) dut (
        .clk      (clk),
        .resetn   (resetn),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_mode  (in_mode),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_mode (out_mode),
        .out_data (out_data)
`ifdef GRAY_CODEC_STEP_CHK_EN
        ,
        .step_err (step_err)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         mode;
        logic [W-1:0] data;
        logic         err;
    } beat_t;

    typedef struct {
        logic         mode;
        logic [W-1:0] din;
        logic [W-1:0] dout;
    } vec_t;

    beat_t        exp_q[$];
    logic [W-1:0] seen_q[$];
    int           tests = 0;
    int           fails = 0;
    bit           alive = 1'b0;
    bit           have_prev = 1'b0;
    logic [W-1:0] prev_g = '0;

    // Reference conversion straight from the bit-level definitions.
    function automatic logic [W-1:0] ref_conv(logic mode, logic [W-1:0] x);
        logic [W-1:0] r;
        r = '0;
        if (mode) r = x ^ (x >> 1);
        else
            for (int i = 0; i < W; i++) r[i] = (($countones(x >> i) % 2) == 1);
        return r;
    endfunction

    task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(logic v, logic m, logic [W-1:0] d, logic r);
        in_valid  = v;
        in_mode   = m;
        in_data   = d;
        out_ready = r;
    endtask

    always @(posedge clk or negedge resetn) begin
        if (!resetn) alive <= 1'b0;
        else         alive <= 1'b1;
    end

    // Monitor: sampled mid-cycle, when inputs and combinational outputs are settled.
    always @(negedge clk) begin
        beat_t b;
        if (!resetn) begin
            chk("rst_in_ready", in_ready, 0);
            chk("rst_out_valid", out_valid, 0);
            chk("rst_out_data", out_data, 0);
            chk("rst_out_mode", out_mode, 0);
            exp_q.delete();
            have_prev = 1'b0;
            prev_g    = '0;
        end else begin
            chk("in_ready", in_ready, (alive && (exp_q.size() < S || out_ready)));
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_out_valid", out_valid, 0);
                end else begin
                    chk("out_data", out_data, exp_q[0].data);
                    chk("out_mode", out_mode, exp_q[0].mode);
`ifdef GRAY_CODEC_STEP_CHK_EN
                    chk("step_err", step_err, exp_q[0].err);
`endif
                    if (out_ready) begin
                        $display("[TB] deliver mode=%0d data=%h", out_mode, out_data);
                        seen_q.push_back(out_data);
                        void'(exp_q.pop_front());
                    end
                end
            end
            if (in_valid && in_ready) begin
                b.mode = in_mode;
                b.data = ref_conv(in_mode, in_data);
                b.err  = 1'b0;
                if (!in_mode) begin
                    b.err     = have_prev && ($countones(in_data ^ prev_g) != 1);
                    prev_g    = in_data;
                    have_prev = 1'b1;
                end
                exp_q.push_back(b);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t         vecs [8];
        logic [W-1:0] gray_tab [16];
        logic [W-1:0] hold;
        int           acc;

        vecs[0] = '{1'b0, 16'h000B, 16'h000D};
        vecs[1] = '{1'b1, 16'h000D, 16'h000B};
        vecs[2] = '{1'b0, 16'h8000, 16'hFFFF};
        vecs[3] = '{1'b1, 16'h00FF, 16'h0080};
        vecs[4] = '{1'b0, 16'h0000, 16'h0000};
        vecs[5] = '{1'b1, 16'hFFFF, 16'h8000};
        vecs[6] = '{1'b0, 16'hFFFF, 16'hAAAA};
        vecs[7] = '{1'b1, 16'hAAAA, 16'hFFFF};
        gray_tab = '{16'h0, 16'h1, 16'h3, 16'h2, 16'h6, 16'h7, 16'h5, 16'h4,
                     16'hC, 16'hD, 16'hF, 16'hE, 16'hA, 16'hB, 16'h9, 16'h8};

        repeat (2) step();
        resetn = 1'b1;
        #1 chk("in_ready_before_first_edge", in_ready, 0);
        step();
        chk("in_ready_after_first_edge", in_ready, 1);

        // Single beats: latency, data and mode per table entry.
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, vecs[i].mode, vecs[i].din, 1'b1);
            #1 chk("vec_accept_ready", in_ready, 1);
            step();
            drive(1'b0, 1'b0, '0, 1'b1);
            #1 chk("vec_lat_early", out_valid, 0);
            step();
            chk("vec_valid", out_valid, 1);
            chk("vec_data", out_data, vecs[i].dout);
            chk("vec_mode", out_mode, vecs[i].mode);
            step();
            chk("vec_drained", out_valid, 0);
        end

        // Encode stream 0..15 at full rate.
        seen_q.delete();
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 1'b1, W'(i), 1'b1);
            #1 chk("stream_in_ready", in_ready, 1);
            step();
        end
        drive(1'b0, 1'b0, '0, 1'b1);
        repeat (4) step();
        chk("stream_count", seen_q.size(), 16);
        for (int i = 0; i < 16 && i < seen_q.size(); i++)
            chk("stream_gray", seen_q[i], gray_tab[i]);

        // Stalled output: only S beats fit, output must hold steady.
        acc = 0;
        for (int c = 0; c < 6; c++) begin
            drive(1'b1, 1'($urandom), W'($urandom), 1'b0);
            #1 if (in_ready) acc++;
            step();
        end
        chk("full_accepts", acc, S);
        chk("full_in_ready", in_ready, 0);
        chk("full_out_valid", out_valid, 1);
        hold = out_data;
        step();
        chk("full_stable", out_data, hold);
        for (int c = 0; c < 4; c++) begin
            drive(1'b1, 1'($urandom), W'($urandom), 1'b1);
            #1 chk("full_simul_ready", in_ready, 1);
            step();
        end
        drive(1'b0, 1'b0, '0, 1'b1);
        repeat (4) step();
        chk("full_drained", exp_q.size(), 0);

        // Reset with beats in flight.
        drive(1'b1, 1'b0, 16'h1234, 1'b0);
        repeat (2) step();
        drive(1'b0, 1'b0, '0, 1'b0);
        resetn = 1'b0;
        #1 chk("rst_mid_out_valid", out_valid, 0);
        chk("rst_mid_in_ready", in_ready, 0);
        step();
        resetn = 1'b1;
        #1 chk("rst_release_in_ready", in_ready, 0);
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            chk("rst_no_stale", out_valid, 0);
        end
        chk("rst_ready_again", in_ready, 1);

        // Step-check sequence; the encode beat must not disturb the stored word.
        drive(1'b1, 1'b0, 16'h0000, 1'b1); step();
        drive(1'b1, 1'b0, 16'h0001, 1'b1); step();
        drive(1'b1, 1'b0, 16'h0003, 1'b1); step();
        drive(1'b1, 1'b1, 16'h0005, 1'b1); step();
        drive(1'b1, 1'b0, 16'h0000, 1'b1); step();
        drive(1'b1, 1'b0, 16'h0000, 1'b1); step();
        drive(1'b0, 1'b0, '0, 1'b1);
        repeat (4) step();

        // Randomized traffic with random backpressure and mixed modes.
        for (int c = 0; c < 400; c++) begin
            drive(($urandom % 4) != 0, 1'($urandom), W'($urandom), ($urandom % 3) != 0);
            step();
        end
        drive(1'b0, 1'b0, '0, 1'b1);
        for (int c = 0; c < 20 && exp_q.size() != 0; c++) step();
        chk("final_drain", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
